window_checker: RTL and testbench

Synthesizable multi-channel response-window monitor: the RTL counterpart of the team's bounded-delay implication properties ("trigger implies response within [MIN:MAX] cycles"). It is generalised across channels and delay windows, and adds error accounting. Each channel arms on a trigger, times the response, and reports pass, early-response or late-response events. The block sits beside handshake logic (req/gnt, en/ok pairs) as an on-chip checker whose outputs can also be targeted by formal cover/assert properties.

---
 rtl/window_checker_if.sv | 29 ++
 rtl/window_checker.sv | 148 ++++++++++++++
 tb/tb_window_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_checker_if.sv
// Handshake bundle between the observed logic and the window checker:
// trigger/response inputs in, per-channel status and error accounting out.
interface window_checker_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic [NCH-1:0]   a;
    logic [NCH-1:0]   b;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   pass;
    logic [NCH-1:0]   err_early;
    logic [NCH-1:0]   err_late;
    logic [NCH-1:0]   err_sticky;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, clr, a, b,
        input  busy, pass, err_early, err_late,
        input  err_sticky, err_cnt
    );

    modport slave (
        input  en, clr, a, b,
        output busy, pass, err_early, err_late,
        output err_sticky, err_cnt
    );
endinterface

// File: rtl/window_checker.sv
// Multi-channel response-window monitor: each channel arms on a trigger
// and reports pass / early / late, with sticky flags and an error count.
module window_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst_n,
    window_checker_if.slave  bus
);
    localparam int DLY_W = $clog2(MAX_DLY + 1);
    localparam int SUM_W = CNT_W + 6;

    localparam logic [DLY_W-1:0] MIN_V   = DLY_W'(MIN_DLY);
    localparam logic [DLY_W-1:0] MAX_V   = DLY_W'(MAX_DLY);
    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } st_e;

    logic [NCH-1:0]   busy_q;
    logic [NCH-1:0]   pass_d, pass_q;
    logic [NCH-1:0]   early_d, early_q;
    logic [NCH-1:0]   late_d, late_q;
    logic [NCH-1:0]   sticky_d, sticky_q;
    logic [NCH-1:0]   err_v;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [SUM_W-1:0] nerr;
    logic [SUM_W-1:0] sum;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        st_e              st_q, st_d;
        logic [DLY_W-1:0] dly_q, dly_d;
        logic             p_d, e_d, l_d;
        logic             is_early, is_ok, is_late, done;

        assign is_early = bus.b[gi] & (dly_q < MIN_V);
        assign is_ok    = bus.b[gi] & ~(dly_q < MIN_V);
        assign is_late  = ~bus.b[gi] & (dly_q == MAX_V);
        assign done     = bus.b[gi] | is_late;

        always_comb begin
            st_d  = st_q;
            dly_d = dly_q;
            p_d   = 1'b0;
            e_d   = 1'b0;
            l_d   = 1'b0;
            if (!bus.en) begin
                st_d  = IDLE;
                dly_d = '0;
            end else begin
                unique case (st_q)
                    IDLE: begin
                        if (bus.a[gi]) begin
                            st_d  = WAIT;
                            dly_d = DLY_ONE;
                        end
                    end
                    WAIT: begin
                        unique case (1'b1)
                            is_early: e_d = 1'b1;
                            is_ok:    p_d = 1'b1;
                            is_late:  l_d = 1'b1;
                            default:  dly_d = dly_q + DLY_ONE;
                        endcase
                        // A trigger on the resolving cycle starts a fresh check
                        if (done) begin
                            st_d  = bus.a[gi] ? WAIT : IDLE;
                            dly_d = bus.a[gi] ? DLY_ONE : '0;
                        end
                    end
                    default: begin
                        st_d  = IDLE;
                        dly_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= IDLE;
                dly_q <= '0;
            end else begin
                st_q  <= st_d;
                dly_q <= dly_d;
            end
        end

        assign busy_q[gi]  = (st_q == WAIT);
        assign pass_d[gi]  = p_d;
        assign early_d[gi] = e_d;
        assign late_d[gi]  = l_d;
    end

    assign err_v = early_d | late_d;

    always_comb begin
        nerr = '0;
        for (int i = 0; i < NCH; i++) begin
            nerr = nerr + SUM_W'(err_v[i]);
        end
    end

    assign sum = SUM_W'(cnt_q) + nerr;

    // Clear wins over same-cycle errors; the pulses still go out
    always_comb begin
        sticky_d = sticky_q | err_v;
        cnt_d    = cnt_q;
        if (bus.clr) begin
            sticky_d = '0;
            cnt_d    = '0;
        end else if (sum > SUM_W'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q   <= '0;
            early_q  <= '0;
            late_q   <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            pass_q   <= pass_d;
            early_q  <= early_d;
            late_q   <= late_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.pass       = pass_q;
    assign bus.err_early  = early_q;
    assign bus.err_late   = late_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = cnt_q;
endmodule

// File: tb/tb_window_checker.sv
// Scoreboard bench for window_checker: a timestamp-based model pushes the
// expected output word per cycle; each scenario task pops and compares.
module tb_window_checker;
    localparam int NCH     = 4;
    localparam int MIN_DLY = 2;
    localparam int MAX_DLY = 3;
    localparam int CNT_W   = 2;

    typedef struct packed {
        logic [NCH-1:0]   busy;
        logic [NCH-1:0]   pass;
        logic [NCH-1:0]   early;
        logic [NCH-1:0]   late;
        logic [NCH-1:0]   sticky;
        logic [CNT_W-1:0] cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_checker_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    window_checker #(
        .NCH(NCH), .MIN_DLY(MIN_DLY),
        .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    out_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   m_busy[NCH];
    int   m_arm[NCH];
    out_t m_out;

    function automatic out_t obs();
        out_t o;
        o.busy   = bus.busy;
        o.pass   = bus.pass;
        o.early  = bus.err_early;
        o.late   = bus.err_late;
        o.sticky = bus.err_sticky;
        o.cnt    = bus.err_cnt;
        return o;
    endfunction

    task automatic m_reset();
        m_out = '0;
        for (int i = 0; i < NCH; i++) m_busy[i] = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the registered result, clock it in
    task automatic tick(input bit en, input bit clr,
                        input logic [NCH-1:0] a,
                        input logic [NCH-1:0] b);
        out_t n;
        int   d, k, nc;
        bit   fin;
        bus.en  = en;
        bus.clr = clr;
        bus.a   = a;
        bus.b   = b;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!en) begin
                m_busy[i] = 1'b0;
            end else if (!m_busy[i]) begin
                if (a[i]) begin
                    m_busy[i] = 1'b1;
                    m_arm[i]  = cyc;
                end
            end else begin
                d   = cyc - m_arm[i];
                fin = 1'b0;
                if (b[i]) begin
                    fin = 1'b1;
                    if (d < MIN_DLY) n.early[i] = 1'b1;
                    else n.pass[i] = 1'b1;
                end else if (d >= MAX_DLY) begin
                    fin = 1'b1;
                    n.late[i] = 1'b1;
                end
                if (fin) begin
                    m_busy[i] = a[i];
                    m_arm[i]  = cyc;
                end
            end
            n.busy[i] = m_busy[i];
        end
        k = $countones(n.early | n.late);
        if (clr) begin
            n.sticky = '0;
            n.cnt    = '0;
        end else begin
            n.sticky = m_out.sticky | n.early | n.late;
            nc = int'(m_out.cnt) + k;
            if (nc > (1 << CNT_W) - 1) nc = (1 << CNT_W) - 1;
            n.cnt = CNT_W'(nc);
        end
        m_out = n;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        out_t o;
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        rst_n   = 1'b0;
        m_reset();
        #12;
        o = obs();
        checks++;
        if (o !== out_t'(0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass();
        logic [NCH-1:0] av[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [NCH-1:0] bv[9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        out_t e, o;
        int   np = 0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b1, 1'b0, av[k], bv[k]);
            e = exp_q.pop_front();
            o = obs();
            np += int'(o.pass[0]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pass step=%0d got=%h exp=%h", k, o, e);
            end
        end
        checks++;
        if (np != 2 || bus.err_cnt !== 2'd0) begin
            failures++;
            $display("FAIL pass_count got=%0d cnt=%0d exp=2 cnt=0",
                     np, bus.err_cnt);
        end
    endtask

    task automatic test_late();
        logic [NCH-1:0] av[7] = '{0, 2, 0, 0, 0, 0, 0};
        logic [NCH-1:0] bv[7] = '{2, 0, 0, 0, 0, 0, 0};
        out_t e, o;
        int   nl = 0;
        for (int k = 0; k < 7; k++) begin
            tick(1'b1, 1'b0, av[k], bv[k]);
            e = exp_q.pop_front();
            o = obs();
            nl += int'(o.late[1]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL late step=%0d got=%h exp=%h", k, o, e);
            end
        end
        checks++;
        if (nl != 1 || bus.err_sticky !== 4'h2 || bus.err_cnt !== 2'd1) begin
            failures++;
            $display("FAIL late_acct got=%0d/%h/%0d exp=1/2/1",
                     nl, bus.err_sticky, bus.err_cnt);
        end
    endtask

    task automatic test_early();
        logic [NCH-1:0] av[9] = '{4, 0, 0, 4, 4, 0, 0, 0, 0};
        logic [NCH-1:0] bv[9] = '{0, 4, 0, 0, 0, 0, 0, 0, 0};
        out_t e, o;
        int   ne = 0;
        int   nl = 0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b1, 1'b0, av[k], bv[k]);
            e = exp_q.pop_front();
            o = obs();
            ne += int'(o.early[2]);
            nl += int'(o.late[2]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL early step=%0d got=%h exp=%h", k, o, e);
            end
        end
        checks++;
        if (ne != 1 || nl != 1) begin
            failures++;
            $display("FAIL early_count got=%0d/%0d exp=1/1", ne, nl);
        end
    endtask

    task automatic test_rearm();
        logic [NCH-1:0] av[8] = '{8, 0, 0, 8, 0, 0, 0, 0};
        logic [NCH-1:0] bv[8] = '{0, 0, 0, 8, 0, 8, 0, 0};
        out_t e, o;
        int   np = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b0, av[k], bv[k]);
            e = exp_q.pop_front();
            o = obs();
            np += int'(o.pass[3]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rearm step=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 3) begin
                checks++;
                if (o.busy[3] !== 1'b1 || o.pass[3] !== 1'b1) begin
                    failures++;
                    $display("FAIL rearm_busy got=%b%b exp=11",
                             o.busy[3], o.pass[3]);
                end
            end
        end
        checks++;
        if (np != 2) begin
            failures++;
            $display("FAIL rearm_count got=%0d exp=2", np);
        end
    endtask

    task automatic test_saturate();
        logic [NCH-1:0] av[10] = '{0, 15, 0, 0, 0, 1, 0, 0, 0, 0};
        bit             cv[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        out_t e, o;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, cv[k], av[k], '0);
            e = exp_q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL saturate step=%0d got=%h exp=%h", k, o, e);
            end
            if (k == 4) begin
                checks++;
                if (o.cnt !== 2'd3 || o.late !== 4'hf) begin
                    failures++;
                    $display("FAIL sat_cnt got=%0d/%h exp=3/f",
                             o.cnt, o.late);
                end
            end
            if (k == 8) begin
                checks++;
                if (o.late !== 4'h1 || o.cnt !== 2'd0 || o.sticky !== 4'h0) begin
                    failures++;
                    $display("FAIL clr_beats got=%h/%0d/%h exp=1/0/0",
                             o.late, o.cnt, o.sticky);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit   ev[6] = '{1, 0, 1, 1, 1, 1};
        out_t e, o;
        int   nev = 0;
        for (int k = 0; k < 6; k++) begin
            tick(ev[k], 1'b0, (k == 0) ? 4'h1 : 4'h0, '0);
            e = exp_q.pop_front();
            o = obs();
            nev += $countones(o.pass | o.early | o.late);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL abort step=%0d got=%h exp=%h", k, o, e);
            end
        end
        checks++;
        if (nev != 0) begin
            failures++;
            $display("FAIL abort_pulses got=%0d exp=0", nev);
        end
    endtask

    task automatic test_reset_mid();
        out_t e, o;
        tick(1'b1, 1'b0, 4'h2, '0);
        e = exp_q.pop_front();
        tick(1'b1, 1'b0, 4'h0, '0);
        e = exp_q.pop_front();
        o = obs();
        checks++;
        if (o.busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=1", o.busy[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        o = obs();
        checks++;
        if (o !== out_t'(0)) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        out_t e, o;
        bit   en, clr;
        for (int k = 0; k < 400; k++) begin
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 31) == 0);
            tick(en, clr, NCH'($urandom_range(0, 15)),
                 NCH'($urandom_range(0, 15) & $urandom_range(0, 15)));
            e = exp_q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random step=%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_late();
        test_early();
        test_rearm();
        test_saturate();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
